// File: rtl/video_pattern_pkg.sv
// Shared types and the per-pixel pattern function for the video pattern generator.
// Imported by the timing sub-module and the top level.
package video_pattern_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_HBLANK = 2'd2,
        ST_VBLANK = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        PAT_HRAMP   = 2'd0,
        PAT_VRAMP   = 2'd1,
        PAT_CHECKER = 2'd2,
        PAT_CONST   = 2'd3
    } pattern_t;

    localparam int CHECKER_BIT = 4;

    // Returns a full 32-bit value; callers truncate to their pixel width, which
    // yields the mod 2^PX_WIDTH ramps and an all-ones checker square for free.
    function automatic logic [31:0] pixel_value(
        input logic [31:0] x,
        input logic [31:0] y,
        input pattern_t    pat,
        input logic [31:0] cval
    );
        logic [31:0] v;
        v = '0;
        case (pat)
            PAT_HRAMP:   v = x;
            PAT_VRAMP:   v = y;
            PAT_CHECKER: v = (x[CHECKER_BIT] ^ y[CHECKER_BIT]) ? '1 : '0;
            default:     v = cval;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/video_pattern_timing.sv
// Frame timing engine: IDLE/ACTIVE/HBLANK/VBLANK state machine with word, line and
// blanking counters. Latches the frame configuration on every frame start.
module video_pattern_timing
    import video_pattern_pkg::*;
#(
    parameter  int PX_WIDTH        = 12,
    parameter  int PX_PER_CLK      = 4,
    parameter  int MAX_LINE_SIZE   = 4112,
    parameter  int MAX_FRAME_LINES = 4096,
    parameter  int BLANK_W         = 16,
    localparam int LS_W            = $clog2(MAX_LINE_SIZE + 1),
    localparam int FL_W            = $clog2(MAX_FRAME_LINES + 1),
    localparam int LN_W            = $clog2(PX_PER_CLK + 1)
) (
    input  logic                i_clk,
    input  logic                i_rstN,
    input  logic                i_en,
    input  logic [LS_W-1:0]     i_lineSize,
    input  logic [FL_W-1:0]     i_frameLines,
    input  logic [BLANK_W-1:0]  i_hblank,
    input  logic [BLANK_W-1:0]  i_vblank,
    input  logic [1:0]          i_pattern,
    input  logic [PX_WIDTH-1:0] i_const,
    output logic                o_active,
    output logic [LS_W-1:0]     o_wordIdx,
    output logic [FL_W-1:0]     o_lineIdx,
    output logic                o_lineFirst,
    output logic                o_lineLast,
    output logic                o_frameFirst,
    output logic                o_frameLast,
    output logic [LN_W-1:0]     o_lastLanes,
    output pattern_t            o_pattern,
    output logic [PX_WIDTH-1:0] o_const,
    output logic                o_busy
);

    state_t               r_state;
    logic [LS_W-1:0]      r_wordIdx;
    logic [FL_W-1:0]      r_lineIdx;
    logic [BLANK_W-1:0]   r_blankCnt;
    logic [LS_W-1:0]      r_wordsPerLine;
    logic [FL_W-1:0]      r_frameLines;
    logic [BLANK_W-1:0]   r_hblank;
    logic [BLANK_W-1:0]   r_vblank;
    logic [LN_W-1:0]      r_lastLanes;
    pattern_t             r_pattern;
    logic [PX_WIDTH-1:0]  r_const;

    state_t               w_stateNext;
    logic [LS_W-1:0]      w_wordIdxNext;
    logic [FL_W-1:0]      w_lineIdxNext;
    logic [BLANK_W-1:0]   w_blankCntNext;
    logic                 w_load;
    logic                 w_startOk;
    logic                 w_lineLast;
    logic                 w_frameLast;
    logic [LS_W-1:0]      w_lineSizeClamp;
    logic [FL_W-1:0]      w_frameLinesClamp;
    logic [LS_W-1:0]      w_wordsPerLine;
    logic [31:0]          w_rem;
    logic [LN_W-1:0]      w_lastLanes;

    assign w_lineSizeClamp   = (i_lineSize > LS_W'(MAX_LINE_SIZE)) ? LS_W'(MAX_LINE_SIZE) : i_lineSize;
    assign w_frameLinesClamp = (i_frameLines > FL_W'(MAX_FRAME_LINES)) ? FL_W'(MAX_FRAME_LINES) : i_frameLines;
    assign w_wordsPerLine    = LS_W'((32'(w_lineSizeClamp) + 32'(PX_PER_CLK) - 32'd1) / 32'(PX_PER_CLK));
    assign w_rem             = 32'(w_lineSizeClamp) % 32'(PX_PER_CLK);
    assign w_lastLanes       = (w_rem == 32'd0) ? LN_W'(PX_PER_CLK) : LN_W'(w_rem);

    // Zero geometry never starts a frame, whether from IDLE or at the end of VBLANK.
    assign w_startOk   = i_en && (i_lineSize != '0) && (i_frameLines != '0);
    assign w_lineLast  = (r_wordIdx == r_wordsPerLine - LS_W'(1));
    assign w_frameLast = (r_lineIdx == r_frameLines - FL_W'(1));

    always_comb begin
        w_stateNext    = r_state;
        w_wordIdxNext  = r_wordIdx;
        w_lineIdxNext  = r_lineIdx;
        w_blankCntNext = r_blankCnt;
        w_load         = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_startOk) begin
                    w_load        = 1'b1;
                    w_stateNext   = ST_ACTIVE;
                    w_wordIdxNext = '0;
                    w_lineIdxNext = '0;
                end
            end
            ST_ACTIVE: begin
                if (!w_lineLast) begin
                    w_wordIdxNext = r_wordIdx + LS_W'(1);
                end else begin
                    w_wordIdxNext = '0;
                    if (!w_frameLast) begin
                        w_lineIdxNext = r_lineIdx + FL_W'(1);
                        if (r_hblank != '0) begin
                            w_stateNext    = ST_HBLANK;
                            w_blankCntNext = r_hblank - BLANK_W'(1);
                        end
                    end else if (r_vblank != '0) begin
                        w_stateNext    = ST_VBLANK;
                        w_blankCntNext = r_vblank - BLANK_W'(1);
                    end else begin
                        w_lineIdxNext = '0;
                        w_load        = w_startOk;
                        w_stateNext   = w_startOk ? ST_ACTIVE : ST_IDLE;
                    end
                end
            end
            ST_HBLANK: begin
                if (r_blankCnt == '0) begin
                    w_stateNext = ST_ACTIVE;
                end else begin
                    w_blankCntNext = r_blankCnt - BLANK_W'(1);
                end
            end
            ST_VBLANK: begin
                if (r_blankCnt == '0) begin
                    w_lineIdxNext = '0;
                    w_load        = w_startOk;
                    w_stateNext   = w_startOk ? ST_ACTIVE : ST_IDLE;
                end else begin
                    w_blankCntNext = r_blankCnt - BLANK_W'(1);
                end
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstN) begin
            r_state        <= ST_IDLE;
            r_wordIdx      <= '0;
            r_lineIdx      <= '0;
            r_blankCnt     <= '0;
            r_wordsPerLine <= '0;
            r_frameLines   <= '0;
            r_hblank       <= '0;
            r_vblank       <= '0;
            r_lastLanes    <= '0;
            r_pattern      <= PAT_HRAMP;
            r_const        <= '0;
        end else begin
            r_state    <= w_stateNext;
            r_wordIdx  <= w_wordIdxNext;
            r_lineIdx  <= w_lineIdxNext;
            r_blankCnt <= w_blankCntNext;
            if (w_load) begin
                r_wordsPerLine <= w_wordsPerLine;
                r_frameLines   <= w_frameLinesClamp;
                r_hblank       <= i_hblank;
                r_vblank       <= i_vblank;
                r_lastLanes    <= w_lastLanes;
                r_pattern      <= pattern_t'(i_pattern);
                r_const        <= i_const;
            end
        end
    end

    assign o_active     = (r_state == ST_ACTIVE);
    assign o_wordIdx    = r_wordIdx;
    assign o_lineIdx    = r_lineIdx;
    assign o_lineFirst  = (r_wordIdx == '0);
    assign o_lineLast   = w_lineLast;
    assign o_frameFirst = (r_wordIdx == '0) && (r_lineIdx == '0);
    assign o_frameLast  = w_frameLast;
    assign o_lastLanes  = r_lastLanes;
    assign o_pattern    = r_pattern;
    assign o_const      = r_const;
    assign o_busy       = (r_state != ST_IDLE);

endmodule

// File: rtl/video_pattern_gen.sv
// Multi-pixel-per-clock test pattern source. Turns the timing engine's word/line
// position into packed lane data with a valid mask and registered stream markers.
module video_pattern_gen
    import video_pattern_pkg::*;
#(
    parameter  int PX_WIDTH        = 12,
    parameter  int PX_PER_CLK      = 4,
    parameter  int MAX_LINE_SIZE   = 4112,
    parameter  int MAX_FRAME_LINES = 4096,
    parameter  int BLANK_W         = 16,
    localparam int LS_W            = $clog2(MAX_LINE_SIZE + 1),
    localparam int FL_W            = $clog2(MAX_FRAME_LINES + 1),
    localparam int LN_W            = $clog2(PX_PER_CLK + 1)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           en_i,
    input  logic [LS_W-1:0]                line_size_i,
    input  logic [FL_W-1:0]                frame_lines_i,
    input  logic [BLANK_W-1:0]             hblank_i,
    input  logic [BLANK_W-1:0]             vblank_i,
    input  logic [1:0]                     pattern_i,
    input  logic [PX_WIDTH-1:0]            const_i,
    output logic [PX_PER_CLK*PX_WIDTH-1:0] px_data_o,
    output logic [PX_PER_CLK-1:0]          px_data_val_o,
    output logic                           line_start_o,
    output logic                           line_end_o,
    output logic                           frame_start_o,
    output logic                           frame_end_o,
    output logic                           busy_o
);

    logic                           w_active;
    logic [LS_W-1:0]                w_wordIdx;
    logic [FL_W-1:0]                w_lineIdx;
    logic                           w_lineFirst;
    logic                           w_lineLast;
    logic                           w_frameFirst;
    logic                           w_frameLast;
    logic [LN_W-1:0]                w_lastLanes;
    pattern_t                       w_pattern;
    logic [PX_WIDTH-1:0]            w_const;
    logic                           w_busy;
    logic [LN_W-1:0]                w_validLanes;
    logic [PX_PER_CLK*PX_WIDTH-1:0] w_pxData;
    logic [PX_PER_CLK-1:0]          w_pxVal;

    logic [PX_PER_CLK*PX_WIDTH-1:0] r_pxData;
    logic [PX_PER_CLK-1:0]          r_pxVal;
    logic                           r_lineStart;
    logic                           r_lineEnd;
    logic                           r_frameStart;
    logic                           r_frameEnd;

    video_pattern_timing #(
        .PX_WIDTH        (PX_WIDTH),
        .PX_PER_CLK      (PX_PER_CLK),
        .MAX_LINE_SIZE   (MAX_LINE_SIZE),
        .MAX_FRAME_LINES (MAX_FRAME_LINES),
        .BLANK_W         (BLANK_W)
    ) u_timing (
        .i_clk        (clk_i),
        .i_rstN       (rst_i),
        .i_en         (en_i),
        .i_lineSize   (line_size_i),
        .i_frameLines (frame_lines_i),
        .i_hblank     (hblank_i),
        .i_vblank     (vblank_i),
        .i_pattern    (pattern_i),
        .i_const      (const_i),
        .o_active     (w_active),
        .o_wordIdx    (w_wordIdx),
        .o_lineIdx    (w_lineIdx),
        .o_lineFirst  (w_lineFirst),
        .o_lineLast   (w_lineLast),
        .o_frameFirst (w_frameFirst),
        .o_frameLast  (w_frameLast),
        .o_lastLanes  (w_lastLanes),
        .o_pattern    (w_pattern),
        .o_const      (w_const),
        .o_busy       (w_busy)
    );

    // Only the last word of a line can be partial; its lane count was fixed at frame start.
    assign w_validLanes = w_lineLast ? w_lastLanes : LN_W'(PX_PER_CLK);

    always_comb begin
        w_pxData = '0;
        w_pxVal  = '0;
        for (int l = 0; l < PX_PER_CLK; l++) begin
            if (w_active && (LN_W'(l) < w_validLanes)) begin
                w_pxVal[l] = 1'b1;
                w_pxData[l*PX_WIDTH +: PX_WIDTH] = PX_WIDTH'(pixel_value(
                    32'(w_wordIdx) * 32'(PX_PER_CLK) + 32'(l),
                    32'(w_lineIdx),
                    w_pattern,
                    32'(w_const)));
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_pxData     <= '0;
            r_pxVal      <= '0;
            r_lineStart  <= 1'b0;
            r_lineEnd    <= 1'b0;
            r_frameStart <= 1'b0;
            r_frameEnd   <= 1'b0;
        end else begin
            r_pxData     <= w_pxData;
            r_pxVal      <= w_pxVal;
            r_lineStart  <= w_active && w_lineFirst;
            r_lineEnd    <= w_active && w_lineLast;
            r_frameStart <= w_active && w_frameFirst;
            r_frameEnd   <= w_active && w_lineLast && w_frameLast;
        end
    end

    assign px_data_o     = r_pxData;
    assign px_data_val_o = r_pxVal;
    assign line_start_o  = r_lineStart;
    assign line_end_o    = r_lineEnd;
    assign frame_start_o = r_frameStart;
    assign frame_end_o   = r_frameEnd;
    assign busy_o        = w_busy;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Scoreboard bench for video_pattern_gen: a frame-level model queues every expected
// word with its arrival cycle; a negedge monitor pops and compares as words appear.
module tb_video_pattern_gen;

    typedef struct {
        longint     cyc;
        logic [47:0] data;
        logic [3:0]  val;
        logic        ls;
        logic        le;
        logic        fs;
        logic        fe;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        en_i;
    logic [12:0] line_size_i;
    logic [12:0] frame_lines_i;
    logic [15:0] hblank_i;
    logic [15:0] vblank_i;
    logic [1:0]  pattern_i;
    logic [11:0] const_i;
    logic [47:0] px_data_o;
    logic [3:0]  px_data_val_o;
    logic        line_start_o;
    logic        line_end_o;
    logic        frame_start_o;
    logic        frame_end_o;
    logic        busy_o;

    exp_t   sbq[$];
    longint cycle = 0;
    int     nTests = 0;
    int     nFail  = 0;

    video_pattern_gen dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .en_i          (en_i),
        .line_size_i   (line_size_i),
        .frame_lines_i (frame_lines_i),
        .hblank_i      (hblank_i),
        .vblank_i      (vblank_i),
        .pattern_i     (pattern_i),
        .const_i       (const_i),
        .px_data_o     (px_data_o),
        .px_data_val_o (px_data_val_o),
        .line_start_o  (line_start_o),
        .line_end_o    (line_end_o),
        .frame_start_o (frame_start_o),
        .frame_end_o   (frame_end_o),
        .busy_o        (busy_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", name, cycle, got, exp);
        end
    endtask

    function automatic logic [11:0] refPixel(input int x, input int y, input int pat, input logic [11:0] c);
        case (pat)
            0:       return 12'(x % 4096);
            1:       return 12'(y % 4096);
            2:       return (((x / 16) % 2) != ((y / 16) % 2)) ? 12'hFFF : 12'h000;
            default: return c;
        endcase
    endfunction

    // Frame-level model: lists every word of every frame with the cycle it must appear in.
    task automatic modelPush(input int ls, input int lines, input int hb, input int vb, input int pat,
                             input logic [11:0] c, input int frames, input longint startEdge,
                             output longint dropAt, output longint lastEnd);
        int     els;
        int     elines;
        longint t;
        longint prevEnd;
        exp_t   e;
        els     = (ls > 4112) ? 4112 : ls;
        elines  = (lines > 4096) ? 4096 : lines;
        t       = startEdge + 1;
        prevEnd = startEdge;
        dropAt  = startEdge;
        for (int f = 0; f < frames; f++) begin
            if (f == frames - 1) dropAt = prevEnd;
            for (int y = 0; y < elines; y++) begin
                for (int w = 0; w * 4 < els; w++) begin
                    e.cyc  = t;
                    e.data = '0;
                    e.val  = '0;
                    for (int l = 0; l < 4; l++) begin
                        if (w * 4 + l < els) begin
                            e.val[l] = 1'b1;
                            e.data[l*12 +: 12] = refPixel(w * 4 + l, y, pat, c);
                        end
                    end
                    e.ls = (w == 0);
                    e.le = ((w + 1) * 4 >= els);
                    e.fs = (w == 0) && (y == 0);
                    e.fe = e.le && (y == elines - 1);
                    sbq.push_back(e);
                    t++;
                end
                if (y < elines - 1) t += hb;
            end
            prevEnd = t - 1 + vb;
            t       = prevEnd + 1;
        end
        lastEnd = prevEnd;
    endtask

    task automatic waitCycle(input longint target);
        while (cycle < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called #1 after an edge with the DUT idle; runs exactly 'frames' frames.
    task automatic applyStimulus(input int ls, input int lines, input int hb, input int vb, input int pat,
                                 input logic [11:0] c, input int frames, input int newLs);
        longint startEdge;
        longint dropAt;
        longint lastEnd;
        line_size_i   = 13'(ls);
        frame_lines_i = 13'(lines);
        hblank_i      = 16'(hb);
        vblank_i      = 16'(vb);
        pattern_i     = 2'(pat);
        const_i       = c;
        en_i          = 1'b1;
        startEdge     = cycle + 1;
        modelPush(ls, lines, hb, vb, pat, c, frames, startEdge, dropAt, lastEnd);
        waitCycle(dropAt);
        en_i = 1'b0;
        if (newLs != 0) line_size_i = 13'(newLs);
        waitCycle(lastEnd - 1);
        checkOutput("busy in frame", 64'(busy_o), 64'd1);
        waitCycle(lastEnd);
        checkOutput("busy after frames", 64'(busy_o), 64'd0);
        waitCycle(lastEnd + 1);
        checkOutput("scoreboard drained", 64'(sbq.size()), 64'd0);
        sbq.delete();
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (sbq.size() > 0 && sbq[0].cyc < cycle) begin
            checkOutput("missing word", 64'(cycle), 64'(sbq[0].cyc));
            void'(sbq.pop_front());
        end
        if (px_data_val_o != 4'd0) begin
            if (sbq.size() == 0) begin
                checkOutput("unexpected word", 64'(px_data_val_o), 64'd0);
            end else begin
                e = sbq.pop_front();
                checkOutput("word cycle", 64'(cycle), 64'(e.cyc));
                checkOutput("word content",
                    64'({px_data_o, px_data_val_o, line_start_o, line_end_o, frame_start_o, frame_end_o}),
                    64'({e.data, e.val, e.ls, e.le, e.fs, e.fe}));
            end
        end else begin
            checkOutput("idle outputs",
                64'({px_data_o, line_start_o, line_end_o, frame_start_o, frame_end_o}), 64'd0);
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        longint startEdge;
        longint dummyA;
        longint dummyB;
        rst_i         = 1'b0;
        en_i          = 1'b0;
        line_size_i   = '0;
        frame_lines_i = '0;
        hblank_i      = '0;
        vblank_i      = '0;
        pattern_i     = '0;
        const_i       = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset outputs",
            64'({px_data_o, px_data_val_o, line_start_o, line_end_o, frame_start_o, frame_end_o}), 64'd0);
        checkOutput("reset busy", 64'(busy_o), 64'd0);
        rst_i = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] directed: line 8, 2 lines, hblank 3, vblank 5, h-ramp, 2 frames");
        applyStimulus(8, 2, 3, 5, 0, 12'h000, 2, 0);
        $display("[TB] directed: line 10, constant 0xABC");
        applyStimulus(10, 2, 1, 2, 3, 12'hABC, 1, 0);
        $display("[TB] directed: single-pixel frames back to back");
        applyStimulus(1, 1, 0, 0, 0, 12'h000, 6, 0);
        $display("[TB] directed: en dropped on first word of 4-line frame");
        applyStimulus(8, 4, 2, 3, 1, 12'h000, 1, 0);
        $display("[TB] directed: checker 64x32, line size changed mid-frame");
        applyStimulus(64, 32, 1, 1, 2, 12'h000, 1, 20);
        $display("[TB] directed: line size clamp");
        applyStimulus(5000, 1, 0, 2, 0, 12'h000, 1, 0);

        $display("[TB] directed: zero geometry stays idle");
        en_i          = 1'b1;
        line_size_i   = 13'd0;
        frame_lines_i = 13'd5;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("zero line_size busy", 64'(busy_o), 64'd0);
        line_size_i   = 13'd8;
        frame_lines_i = 13'd0;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("zero frame_lines busy", 64'(busy_o), 64'd0);
        en_i = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] directed: reset on word 2 of line 1");
        line_size_i   = 13'd16;
        frame_lines_i = 13'd2;
        hblank_i      = 16'd3;
        vblank_i      = 16'd2;
        pattern_i     = 2'd0;
        en_i          = 1'b1;
        startEdge     = cycle + 1;
        modelPush(16, 2, 3, 2, 0, 12'h000, 1, startEdge, dummyA, dummyB);
        waitCycle(startEdge + 10);
        @(negedge clk);
        #1;
        rst_i = 1'b0;
        en_i  = 1'b0;
        sbq.delete();
        @(posedge clk);
        #1;
        rst_i = 1'b1;
        checkOutput("outputs after abort",
            64'({px_data_o, px_data_val_o, line_start_o, line_end_o, frame_start_o, frame_end_o}), 64'd0);
        checkOutput("busy after abort", 64'(busy_o), 64'd0);
        applyStimulus(12, 2, 2, 1, 0, 12'h000, 1, 0);

        $display("[TB] randomized configurations");
        for (int i = 0; i < 12; i++) begin
            applyStimulus(int'($urandom_range(1, 40)), int'($urandom_range(1, 4)),
                          int'($urandom_range(0, 4)), int'($urandom_range(0, 5)),
                          int'($urandom_range(0, 3)), 12'($urandom),
                          int'($urandom_range(1, 3)), 0);
        end

        repeat (3) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/video_pattern_gen.md
# video_pattern_gen

Multi-pixel-per-clock video stream source that drives the same stream protocol the windowing path consumes: packed pixel data, per-lane valid, and line/frame start/end markers. It produces a configurable frame geometry with horizontal and vertical blanking, and one of four test patterns. It sits at the head of the processing chain as a bring-up and verification source and as a stand-in for the sensor receiver.

## Interface
- PX_WIDTH, 12, bits per pixel
- PX_PER_CLK, 4, pixels per clock word; lane 0 is the leftmost pixel
- MAX_LINE_SIZE, 4112, maximum pixels per line
- MAX_FRAME_LINES, 4096, maximum lines per frame
- BLANK_W, 16, width of blanking counters

- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-low
- en_i  in  1  run request
- line_size_i  in  $clog2(MAX_LINE_SIZE+1)  pixels per line
- frame_lines_i  in  $clog2(MAX_FRAME_LINES+1)  lines per frame
- hblank_i  in  BLANK_W  idle cycles between lines
- vblank_i  in  BLANK_W  idle cycles between frames
- pattern_i  in  2  0 = h-ramp, 1 = v-ramp, 2 = checker, 3 = constant
- const_i  in  PX_WIDTH  constant-pattern value
- px_data_o  out  PX_PER_CLK*PX_WIDTH  packed pixels
- px_data_val_o  out  PX_PER_CLK  per-lane valid
- line_start_o / line_end_o  out  1 each  first/last word of a line
- frame_start_o / frame_end_o  out  1 each  first word of the first line / last word of the last line
- busy_o  out  1  high outside IDLE

## Operation
- States: IDLE, ACTIVE, HBLANK, VBLANK.
- Config (line_size_i, frame_lines_i, hblank_i, vblank_i, pattern_i, const_i) is latched on every entry to ACTIVE from IDLE or VBLANK. It is constant within a frame.
- IDLE -> ACTIVE when en_i=1, line_size_i≠0 and frame_lines_i≠0. Zero geometry keeps the block in IDLE.
- ACTIVE emits words_per_line = ceil(line_size/PX_PER_CLK) consecutive words, one per cycle.
- Pixel x = word_idx*PX_PER_CLK + lane; y = line index from 0.
- Last word of a line: valid mask = (1<<(line_size mod PX_PER_CLK))-1, or all ones when the remainder is 0. All other words are all ones.
- Invalid lanes carry data 0. All outputs are 0 in every cycle with no valid word.
- Patterns:
  - h-ramp: x mod 2^PX_WIDTH.
  - v-ramp: y mod 2^PX_WIDTH.
  - checker: all-ones if bit 4 of x XOR bit 4 of y is set, else 0.
  - constant: const_i.
- End of a non-last line:
  - hblank=0: next line starts the following cycle (ACTIVE continues).
  - Otherwise: HBLANK for exactly hblank cycles.
- End of the last line:
  - vblank≠0: VBLANK for vblank cycles.
  - vblank=0: skip VBLANK.
  - Then: if en_i=1, ACTIVE with new frame; else IDLE.
- en_i deassertion mid-frame never truncates the frame. The current frame completes, including VBLANK.

## Timing
- Reset (rst_i=0 at a rising edge): state IDLE, counters 0, all outputs 0 from the next cycle. This holds even mid-line; no line_end/frame_end is emitted for the aborted frame.
- Outputs are registered.
- en_i sampled 1 in IDLE at edge N -> first word (frame_start, line_start) valid after edge N+1.
- Single-word line: line_start and line_end in the same cycle.
- One-line frame: frame_start, line_start, line_end and frame_end can coincide.
- Line period = words_per_line + hblank cycles.
- Frame gap = vblank cycles between the frame_end word and the next frame_start word.
- line_size > MAX_LINE_SIZE or frame_lines > MAX_FRAME_LINES: clamp to the maximum.

## Structure
- Package video_pattern_pkg holds:
  - the state enum;
  - the pattern enum (PAT_HRAMP, PAT_VRAMP, PAT_CHECKER, PAT_CONST);
  - a function computing one pixel from (x, y, pattern, const).
- Sub-module video_pattern_timing: state machine plus word/line/blank counters. It outputs word_idx, y, first/last flags and the active strobe.
- The top level instantiates video_pattern_timing, applies the pixel function across lanes, applies the valid mask, and registers the outputs.

## Test plan
- PX_PER_CLK=4, line 8, lines 2, hblank 3, vblank 5, h-ramp:
  - words 0,1,2,3 / 4,5,6,7 per line, mask 1111;
  - 3 idle cycles between lines, 5 idle cycles between frames;
  - markers exactly on the first/last words.
- Line 10, pattern constant 0xABC: last word mask 0011 with lanes 2–3 data 0; 3 words per line.
- Line 1, lines 1, hblank 0, vblank 0, en_i held: every cycle is one word carrying all four markers, mask 0001.
- en_i dropped on the first word of a 4-line frame: all 4 lines and VBLANK complete, then IDLE with busy_o=0 and outputs 0.
- Reset asserted on word 2 of line 1: all outputs 0 next cycle with no line_end/frame_end; after release with en_i=1, a fresh frame_start appears.
- Checker, line 64, lines 32: pixel (16,0)=0xFFF, (16,16)=0, (0,16)=0xFFF. Changing line_size_i mid-frame has no effect until the next frame.
